mm_ctrl: RTL
============

Name: mm_ctrl

Overview:
- Stream-side sequencer for the matrix-multiply engine `mm_new`.
- Accepts matrix A (M×N words) then matrix B (N×P words) on an input stream and writes them into the A and B BRAMs.
- Holds the engine's Start until Done, then reads the RES BRAM and emits the M×P results on an output stream with TLAST.
- Sits between the AXI-stream coprocessor wrapper and `mm_new` plus its three memories.

Parameters:
- width, 8: bits per data word (stream and memories).
- A_depth_bits, 9: A memory address width.
- B_depth_bits, 9: B memory address width.
- RES_depth_bits, 9: RES memory address width.
- M, 64: rows of A and of RES.
- N, 8: columns of A and rows of B.
- P, 4: columns of B and of RES.

Ports:
- clk  in  1  single clock, all logic on rising edge.
- resetn  in  1  asynchronous, active-low reset.
- s_tdata  in  width  input stream data.
- s_tvalid  in  1  input beat valid.
- s_tready  out  1  input beat accepted.
- s_tlast  in  1  input last marker; ignored, counts are parameter-driven.
- m_tdata  out  width  output stream data.
- m_tvalid  out  1  output beat valid.
- m_tready  in  1  downstream ready.
- m_tlast  out  1  high on the final result beat.
- A_write_en  out  1  A memory write strobe.
- A_write_address  out  A_depth_bits  A write address.
- A_write_data_in  out  width  A write data.
- B_write_en  out  1  B memory write strobe.
- B_write_address  out  B_depth_bits  B write address.
- B_write_data_in  out  width  B write data.
- mm_Start  out  1  level start to the engine.
- mm_Done  in  1  engine completion.
- RES_read_en  out  1  RES memory read enable.
- RES_read_address  out  RES_depth_bits  RES read address.
- RES_read_data_out  in  width  RES data; synchronous read, 1-cycle latency.
- busy  out  1  high in every state except LOAD_A with zero beats received.
- perf_cycles  out  32  compute cycle count (see Optional Feature).

Behaviour:
- Reset (resetn=0, asynchronous):
  - state=LOAD_A; all counters 0.
  - s_tready=0, m_tvalid=0, m_tlast=0.
  - All write enables 0, all addresses and write data 0.
  - mm_Start=0, RES_read_en=1, busy=0, perf_cycles=0.
  - Reset mid-operation abandons the transfer and restarts at LOAD_A; partial memory contents are not cleared.
- LOAD_A:
  - s_tready=1.
  - Each handshake (s_tvalid & s_tready) registers A_write_en=1, A_write_address=cnt, A_write_data_in=s_tdata for exactly one cycle; cnt increments.
  - A_write_en=0 on cycles with no handshake.
  - On the handshake with cnt=M*N-1: cnt←0, go to LOAD_B.
- LOAD_B:
  - Same as LOAD_A using the B port.
  - After N*P beats: s_tready←0, mm_Start←1, go to COMPUTE.
  - s_tready is combinationally high only in LOAD_A/LOAD_B, so no beat is lost at the A→B boundary (back-to-back beats accepted).
- COMPUTE:
  - mm_Start held at 1, s_tready=0.
  - On the first cycle with mm_Done=1: mm_Start←0, go to DRAIN.
- DRAIN:
  - One cycle, so the engine's final RES write (registered together with Done) lands in memory.
  - RES_read_address←0, go to RES_WAIT.
- RES_WAIT:
  - One cycle with the address stable, covering the read latency; go to OUT.
- OUT:
  - m_tvalid=1; m_tdata = RES_read_data_out (direct pass-through, stable because the address is held).
  - m_tlast=1 when the address is M*P-1.
  - m_tvalid/m_tdata are held unchanged while m_tready=0.
  - On handshake, non-last beat: address+1, m_tvalid←0, go to RES_WAIT. Throughput is one word per 2 cycles.
  - On handshake, last beat: go to LOAD_A; busy falls.
- mm_Start is low throughout loading and output, so the engine re-initialises before every run.
- s_tvalid high outside the LOAD states is ignored; s_tready stays 0.
- Address widths: counters are sized so that M*N ≤ 2^A_depth_bits, N*P ≤ 2^B_depth_bits and M*P ≤ 2^RES_depth_bits. No wrap-around can occur at the default parameters.

Optional Feature:
- Macro: MM_CTRL_PERF_EN.
- Defined:
  - perf_cycles clears when COMPUTE is entered and increments on every COMPUTE cycle, including the mm_Done cycle.
  - Holds its value until the next COMPUTE entry or reset; saturates at 2^32-1.
- Undefined: perf_cycles is constant 0 and no counter logic is built.

Test Plan:
- Use M=2, N=2, P=2 with a behavioural mm stub that asserts Done 10 cycles after Start. Send 4 A beats then 4 B beats with continuous valid.
  → A writes at addresses 0..3, B writes at 0..3, mm_Start rises the cycle after the 8th beat.
- Same run with the RES stub preloaded with 11,22,33,44 and m_tready always 1.
  → m_tdata sequence 11,22,33,44, 2 cycles per beat, m_tlast only on 44, busy returns to 0.
- Output backpressure: m_tready=0 for 5 cycles on beat 2.
  → m_tvalid stays 1 and m_tdata stays 22; no duplicated or skipped beats.
- Gapped input: s_tvalid toggles every other cycle.
  → exactly one write strobe per accepted beat, same final addresses; s_tlast ignored.
- Assert resetn=0 during COMPUTE.
  → mm_Start=0 immediately, state LOAD_A, s_tready=1 on the first cycle after release; a full new transfer completes correctly.
- With MM_CTRL_PERF_EN defined and Done 10 cycles after Start → perf_cycles=11. Without the macro → perf_cycles=0.

Source files
------------

// File: rtl/mm_ctrl.sv
// Stream sequencer for mm_new: loads A then B, starts the engine, streams RES out.
// Optional compute-cycle counter enabled by defining MM_CTRL_PERF_EN.
module mm_ctrl #(
  parameter int width          = 8,
  parameter int A_depth_bits   = 9,
  parameter int B_depth_bits   = 9,
  parameter int RES_depth_bits = 9,
  parameter int M              = 64,
  parameter int N              = 8,
  parameter int P              = 4
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic [width-1:0]          s_tdata,
  input  logic                      s_tvalid,
  output logic                      s_tready,
  input  logic                      s_tlast,
  output logic [width-1:0]          m_tdata,
  output logic                      m_tvalid,
  input  logic                      m_tready,
  output logic                      m_tlast,
  output logic                      A_write_en,
  output logic [A_depth_bits-1:0]   A_write_address,
  output logic [width-1:0]          A_write_data_in,
  output logic                      B_write_en,
  output logic [B_depth_bits-1:0]   B_write_address,
  output logic [width-1:0]          B_write_data_in,
  output logic                      mm_Start,
  input  logic                      mm_Done,
  output logic                      RES_read_en,
  output logic [RES_depth_bits-1:0] RES_read_address,
  input  logic [width-1:0]          RES_read_data_out,
  output logic                      busy,
  output logic [31:0]               perf_cycles
);

  localparam int CW = (A_depth_bits > B_depth_bits) ?
                      A_depth_bits : B_depth_bits;
  localparam logic [CW-1:0] A_LAST = CW'(M*N-1);
  localparam logic [CW-1:0] B_LAST = CW'(N*P-1);
  localparam logic [RES_depth_bits-1:0] R_LAST =
    RES_depth_bits'(M*P-1);

  typedef enum logic [2:0] {
    S_LOAD_A, S_LOAD_B, S_COMPUTE, S_DRAIN, S_RES_WAIT, S_OUT
  } state_e;

  state_e                    state_q, state_d;
  logic [CW-1:0]             cnt_q, cnt_d;
  logic                      a_en_q, a_en_d;
  logic [A_depth_bits-1:0]   a_addr_q, a_addr_d;
  logic [width-1:0]          a_data_q, a_data_d;
  logic                      b_en_q, b_en_d;
  logic [B_depth_bits-1:0]   b_addr_q, b_addr_d;
  logic [width-1:0]          b_data_q, b_data_d;
  logic                      start_q, start_d;
  logic [RES_depth_bits-1:0] raddr_q, raddr_d;
  logic                      in_load, s_hs;
  logic                      unused_tlast;

  // Beat counts come from the parameters, so TLAST carries no information.
  assign unused_tlast = s_tlast;

  assign in_load = (state_q == S_LOAD_A) || (state_q == S_LOAD_B);
  assign s_hs    = in_load && s_tvalid;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= S_LOAD_A;
      cnt_q    <= '0;
      a_en_q   <= 1'b0;
      a_addr_q <= '0;
      a_data_q <= '0;
      b_en_q   <= 1'b0;
      b_addr_q <= '0;
      b_data_q <= '0;
      start_q  <= 1'b0;
      raddr_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_en_q   <= a_en_d;
      a_addr_q <= a_addr_d;
      a_data_q <= a_data_d;
      b_en_q   <= b_en_d;
      b_addr_q <= b_addr_d;
      b_data_q <= b_data_d;
      start_q  <= start_d;
      raddr_q  <= raddr_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_en_d   = 1'b0;
    a_addr_d = a_addr_q;
    a_data_d = a_data_q;
    b_en_d   = 1'b0;
    b_addr_d = b_addr_q;
    b_data_d = b_data_q;
    start_d  = start_q;
    raddr_d  = raddr_q;
    unique case (state_q)
      S_LOAD_A: begin
        if (s_hs) begin
          a_en_d   = 1'b1;
          a_addr_d = cnt_q[A_depth_bits-1:0];
          a_data_d = s_tdata;
          if (cnt_q == A_LAST) begin
            cnt_d   = '0;
            state_d = S_LOAD_B;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      S_LOAD_B: begin
        if (s_hs) begin
          b_en_d   = 1'b1;
          b_addr_d = cnt_q[B_depth_bits-1:0];
          b_data_d = s_tdata;
          if (cnt_q == B_LAST) begin
            cnt_d   = '0;
            start_d = 1'b1;
            state_d = S_COMPUTE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      S_COMPUTE: begin
        if (mm_Done) begin
          start_d = 1'b0;
          state_d = S_DRAIN;
        end
      end
      // Lets the engine's last RES write, registered with Done, settle.
      S_DRAIN: begin
        raddr_d = '0;
        state_d = S_RES_WAIT;
      end
      S_RES_WAIT: state_d = S_OUT;
      S_OUT: begin
        if (m_tready) begin
          if (raddr_q == R_LAST) begin
            state_d = S_LOAD_A;
          end else begin
            raddr_d = raddr_q + 1'b1;
            state_d = S_RES_WAIT;
          end
        end
      end
      default: state_d = S_LOAD_A;
    endcase
  end

  always_comb begin
    s_tready         = resetn && in_load;
    m_tvalid         = (state_q == S_OUT);
    m_tlast          = (state_q == S_OUT) && (raddr_q == R_LAST);
    m_tdata          = RES_read_data_out;
    A_write_en       = a_en_q;
    A_write_address  = a_addr_q;
    A_write_data_in  = a_data_q;
    B_write_en       = b_en_q;
    B_write_address  = b_addr_q;
    B_write_data_in  = b_data_q;
    mm_Start         = start_q;
    RES_read_en      = 1'b1;
    RES_read_address = raddr_q;
    busy             = !((state_q == S_LOAD_A) && (cnt_q == '0));
  end

`ifdef MM_CTRL_PERF_EN
  logic [31:0] perf_q, perf_d;

  always_comb begin
    perf_d = perf_q;
    if (state_q == S_LOAD_B && state_d == S_COMPUTE) begin
      perf_d = '0;
    end else if (state_q == S_COMPUTE && perf_q != '1) begin
      perf_d = perf_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) perf_q <= '0;
    else         perf_q <= perf_d;
  end

  assign perf_cycles = perf_q;
`else
  assign perf_cycles = '0;
`endif

endmodule
